// File: rtl/fetch_queue_if.sv
// Bundles the fetch queue's cache, redirect and dequeue signals.
// The master modport is the queue itself; the slave modport is the core/cache side.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            icache_re;
    logic [XLEN-1:0] icache_addr;
    logic [31:0]     icache_dout;
    logic            deq_valid;
    logic            deq_ready;
    logic [31:0]     deq_instr;
    logic [XLEN-1:0] deq_pc;
    logic [CW-1:0]   count;

    modport master (
        input  stall, redirect, redirect_pc, icache_dout, deq_ready,
        output icache_re, icache_addr, deq_valid, deq_instr, deq_pc, count
    );

    modport slave (
        output stall, redirect, redirect_pc, icache_dout, deq_ready,
        input  icache_re, icache_addr, deq_valid, deq_instr, deq_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers the returned
// words in a circular queue and presents them in order. reset_i is active-low.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] inflightPc_q, inflightPc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instrMem_q [DEPTH];
    logic [XLEN-1:0] pcMem_q [DEPTH];

    logic            redirectNow, active, issue, respArrive, bypassMode;
    logic            deqValid, deqFire, bypassTaken, enq, popStore;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] alignedPc;
    logic [31:0]     deqInstr;
    logic [XLEN-1:0] deqPc;

    always_comb begin
        redirectNow = reset_i && !bus.stall && bus.redirect;
        active      = reset_i && !bus.stall && !bus.redirect;
        alignedPc   = fetchPc_q & ALIGN_MASK;
        // The in-flight request reserves a slot so its response always has room.
        occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue       = active && (occupancy < (CW + 1)'(DEPTH));
        respArrive  = active && inflight_q;
        bypassMode  = BYPASS && (count_q == '0);

        if (bypassMode) begin
            deqValid = respArrive;
            deqInstr = bus.icache_dout;
            deqPc    = inflightPc_q;
        end else begin
            deqValid = active && (count_q != '0);
            deqInstr = instrMem_q[rdPtr_q];
            deqPc    = pcMem_q[rdPtr_q];
        end

        deqFire     = deqValid && bus.deq_ready;
        bypassTaken = bypassMode && deqFire;
        enq         = respArrive && !bypassTaken;
        popStore    = deqFire && !bypassMode;
    end

    assign bus.icache_re   = issue;
    assign bus.icache_addr = reset_i ? alignedPc : (RESET_PC & ALIGN_MASK);
    assign bus.deq_valid   = deqValid;
    assign bus.deq_instr   = deqInstr;
    assign bus.deq_pc      = deqPc;
    assign bus.count       = reset_i ? count_q : '0;

    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflightPc_d = inflightPc_q;
        inflight_d   = inflight_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;

        if (redirectNow) begin
            fetchPc_d  = bus.redirect_pc & ALIGN_MASK;
            inflight_d = 1'b0;
            rdPtr_d    = '0;
            wrPtr_d    = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetchPc_d    = fetchPc_q + XLEN'(4);
                inflightPc_d = alignedPc;
                inflight_d   = 1'b1;
            end else if (respArrive) begin
                inflight_d = 1'b0;
            end
            if (enq) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (popStore) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({enq, popStore})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fetchPc_q    <= RESET_PC & ALIGN_MASK;
            inflightPc_q <= '0;
            inflight_q   <= 1'b0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflightPc_q <= inflightPc_d;
            inflight_q   <= inflight_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            instrMem_q[wrPtr_q] <= bus.icache_dout;
            pcMem_q[wrPtr_q]    <= inflightPc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Drives a bypassing and a registered fetch queue with the same directed and random
// stimulus; a scoreboard of issued PCs checks every dequeue for order and content.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        stallR = 1'b0;
    logic        redirectR = 1'b0;
    logic [31:0] redirectPcR = '0;
    logic        deqReady = 1'b1;
    logic [31:0] lastA = '0;
    logic [31:0] lastB = '0;
    logic [31:0] sbA[$];
    logic [31:0] sbB[$];
    int          checks = 0;
    int          errors = 0;
    int          issues;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) ifA ();
    fetch_queue_if #(.XLEN(32), .DEPTH(4)) ifB ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_2000), .BYPASS(1'b1)) dutA (
        .clk_i(clk), .reset_i(resetN), .bus(ifA));
    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_2000), .BYPASS(1'b0)) dutB (
        .clk_i(clk), .reset_i(resetN), .bus(ifB));

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign ifA.stall       = stallR;
    assign ifA.redirect    = redirectR;
    assign ifA.redirect_pc = redirectPcR;
    assign ifA.deq_ready   = deqReady;
    assign ifA.icache_dout = memWord(lastA);
    assign ifB.stall       = stallR;
    assign ifB.redirect    = redirectR;
    assign ifB.redirect_pc = redirectPcR;
    assign ifB.deq_ready   = deqReady;
    assign ifB.icache_dout = memWord(lastB);

    // Instruction memory: answers the address presented in the last non-stall cycle.
    always @(posedge clk) begin
        if (!stallR) begin
            lastA <= ifA.icache_addr;
            lastB <= ifB.icache_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic rdr,
                                 input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        resetN      = rst;
        stallR      = stl;
        redirectR   = rdr;
        redirectPcR = rpc;
        deqReady    = rdy;
        @(negedge clk);
    endtask

    task automatic scoreboardStep(input bit isA, input logic re, input logic [31:0] addr,
                                  input logic dv, input logic [31:0] pc,
                                  input logic [31:0] instr, input logic [2:0] cnt);
        logic [31:0] expPc;
        string       who;
        int          depthNow;
        who = isA ? "A" : "B";
        if (dv && deqReady) begin
            depthNow = isA ? sbA.size() : sbB.size();
            checkOutput({who, ".sbHasEntry"}, depthNow != 0, 1'b1);
            if (depthNow != 0) begin
                expPc = isA ? sbA.pop_front() : sbB.pop_front();
                checkOutput({who, ".sbDeqPc"}, pc, expPc);
                checkOutput({who, ".sbDeqInstr"}, instr, memWord(expPc));
            end
        end
        if (re) begin
            if (isA) sbA.push_back(addr);
            else     sbB.push_back(addr);
        end
        if (redirectR && !stallR) begin
            if (isA) sbA.delete();
            else     sbB.delete();
        end
        checkOutput({who, ".countBound"}, cnt <= 3'd4, 1'b1);
        checkOutput({who, ".noIssueWhenFull"}, re && (cnt == 3'd4), 1'b0);
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            sbA.delete();
            sbB.delete();
        end else begin
            scoreboardStep(1'b1, ifA.icache_re, ifA.icache_addr, ifA.deq_valid,
                           ifA.deq_pc, ifA.deq_instr, ifA.count);
            scoreboardStep(1'b0, ifB.icache_re, ifB.icache_addr, ifB.deq_valid,
                           ifB.deq_pc, ifB.deq_instr, ifB.count);
        end
    end

    initial begin
        $display("[TB] fetch_queue test start");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rst.A.re", ifA.icache_re, 1'b0);
        checkOutput("rst.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("rst.A.count", ifA.count, 3'd0);
        checkOutput("rst.A.addr", ifA.icache_addr, 32'h2000);
        checkOutput("rst.B.re", ifB.icache_re, 1'b0);
        checkOutput("rst.B.deqValid", ifB.deq_valid, 1'b0);
        checkOutput("rst.B.count", ifB.count, 3'd0);
        checkOutput("rst.B.addr", ifB.icache_addr, 32'h2000);

        // Streaming from reset: bypass delivers in cycle 2, registered path in cycle 3.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c1.A.re", ifA.icache_re, 1'b1);
        checkOutput("c1.A.addr", ifA.icache_addr, 32'h2000);
        checkOutput("c1.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("c1.B.addr", ifB.icache_addr, 32'h2000);
        for (int k = 2; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("str.A.addr", ifA.icache_addr, 32'h2000 + 4 * (k - 1));
            checkOutput("str.A.deqValid", ifA.deq_valid, 1'b1);
            checkOutput("str.A.deqPc", ifA.deq_pc, 32'h2000 + 4 * (k - 2));
            checkOutput("str.A.count", ifA.count, 3'd0);
            checkOutput("str.B.deqValid", ifB.deq_valid, k >= 3);
            checkOutput("str.B.count", ifB.count, (k >= 3) ? 3'd1 : 3'd0);
            if (k >= 3) checkOutput("str.B.deqPc", ifB.deq_pc, 32'h2000 + 4 * (k - 3));
        end

        // Redirect while a dequeue would fire: redirect wins.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h3000, 1'b1);
        checkOutput("rdw.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("rdw.A.re", ifA.icache_re, 1'b0);
        checkOutput("rdw.B.deqValid", ifB.deq_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rdw2.A.count", ifA.count, 3'd0);
        checkOutput("rdw2.A.addr", ifA.icache_addr, 32'h3000);
        checkOutput("rdw2.A.re", ifA.icache_re, 1'b1);
        checkOutput("rdw2.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("rdw2.B.count", ifB.count, 3'd0);

        // Fill with consumer blocked: exactly DEPTH issues.
        issues = int'(ifA.icache_re);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            issues += int'(ifA.icache_re);
        end
        checkOutput("fill.A.issues", issues, 4);
        checkOutput("fill.A.count", ifA.count, 3'd4);
        checkOutput("fill.A.re", ifA.icache_re, 1'b0);
        checkOutput("fill.A.deqPc", ifA.deq_pc, 32'h3000);
        checkOutput("fill.B.count", ifB.count, 3'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("pulse.A.deqPc", ifA.deq_pc, 32'h3000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("refill.A.count", ifA.count, 3'd3);
        checkOutput("refill.A.re", ifA.icache_re, 1'b1);
        checkOutput("refill.A.addr", ifA.icache_addr, 32'h3010);
        issues = 1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            issues += int'(ifA.icache_re);
        end
        checkOutput("refill.A.issues", issues, 1);
        checkOutput("refill.A.countFull", ifA.count, 3'd4);

        // Redirect with count=3 and a request in flight; unaligned target.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("pre.A.deqPc", ifA.deq_pc, 32'h3004);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre.A.count", ifA.count, 3'd3);
        checkOutput("pre.A.addr", ifA.icache_addr, 32'h3014);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1003, 1'b0);
        checkOutput("rd.A.count", ifA.count, 3'd3);
        checkOutput("rd.A.deqValid", ifA.deq_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd2.A.count", ifA.count, 3'd0);
        checkOutput("rd2.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("rd2.A.addr", ifA.icache_addr, 32'h1000);
        checkOutput("rd2.A.re", ifA.icache_re, 1'b1);
        checkOutput("rd2.B.addr", ifB.icache_addr, 32'h1000);

        // Three-cycle stall mid-stream.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("pre.A.addr", ifA.icache_addr, 32'h1004 + 4 * j);
            checkOutput("pre.A.deqPc", ifA.deq_pc, 32'h1000 + 4 * j);
            checkOutput("pre.B.deqValid", ifB.deq_valid, j >= 1);
        end
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("stall.A.addr", ifA.icache_addr, 32'h1010);
            checkOutput("stall.A.re", ifA.icache_re, 1'b0);
            checkOutput("stall.A.deqValid", ifA.deq_valid, 1'b0);
            checkOutput("stall.A.count", ifA.count, 3'd0);
            checkOutput("stall.B.count", ifB.count, 3'd1);
            checkOutput("stall.B.deqValid", ifB.deq_valid, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post.A.re", ifA.icache_re, 1'b1);
        checkOutput("post.A.addr", ifA.icache_addr, 32'h1010);
        checkOutput("post.A.deqPc", ifA.deq_pc, 32'h100C);
        checkOutput("post.B.deqPc", ifB.deq_pc, 32'h1008);

        // Random traffic; the scoreboard checks every dequeue.
        for (int k = 0; k < 300; k++) begin
            logic s, r;
            s = ($urandom_range(0, 7) == 0);
            r = !s && ($urandom_range(0, 29) == 0);
            applyStimulus(1'b1, s, r, 32'h4000 + $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation discards everything.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mrst.A.deqValid", ifA.deq_valid, 1'b0);
        checkOutput("mrst.A.re", ifA.icache_re, 1'b0);
        checkOutput("mrst.A.count", ifA.count, 3'd0);
        checkOutput("mrst.A.addr", ifA.icache_addr, 32'h2000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mrst2.A.re", ifA.icache_re, 1'b1);
        checkOutput("mrst2.A.addr", ifA.icache_addr, 32'h2000);
        checkOutput("mrst2.A.count", ifA.count, 3'd0);
        checkOutput("mrst2.A.deqValid", ifA.deq_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mrst3.A.deqPc", ifA.deq_pc, 32'h2000);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
